// File: rtl/byte_serializer_if.sv
// byte_serializer_if -- parallel-in / serial-out bus for byte_serializer.
//   master : producer of words and consumer of the serial stream (drives din, din_valid)
//   slave  : the serializer (drives din_ready, ser_out, ser_valid, byte_done, busy)
// Signals:
//   din[WIDTH-1:0]  word offered for transfer
//   din_valid       din holds a word
//   din_ready       serializer can accept a word this cycle
//   ser_out         serial bit
//   ser_valid       ser_out carries a valid bit
//   byte_done       ser_out carries the last bit of the current word
//   busy            shifting in progress or hold register occupied
interface byte_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             byte_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, ser_out, ser_valid, byte_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ser_out, ser_valid, byte_done, busy
  );
endinterface

// File: rtl/byte_serializer.sv
// byte_serializer -- accepts WIDTH-bit words on a valid/ready handshake and
// shifts them out one bit per cycle, with a one-entry hold register so that
// back-to-back words come out without a gap.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset; aborts any word in flight
//   bus    byte_serializer_if.slave (din/din_valid in; din_ready, ser_out,
//          ser_valid, byte_done, busy out)
// Parameters:
//   WIDTH      word width, 2..32
//   MSB_FIRST  1: din[WIDTH-1] goes out first, 0: din[0] goes out first
module byte_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  byte_serializer_if.slave   bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             xfer;
  logic             last;
  logic             cur_bit;
  logic [WIDTH-1:0] sh_adv;

  // Ready depends only on the hold register and reset, never on din_valid.
  assign bus.din_ready = ~hold_full_q & rst_n;
  assign xfer          = bus.din_valid & bus.din_ready;
  assign last          = (cnt_q == LAST);

  // The bit on ser_out always sits at the outgoing end of the shift register.
  assign cur_bit = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
  assign sh_adv  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

  assign bus.ser_valid = (state_q == SHIFT);
  assign bus.ser_out   = (state_q == SHIFT) & cur_bit;
  assign bus.byte_done = (state_q == SHIFT) & last;
  assign bus.busy      = (state_q == SHIFT) | hold_full_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          sh_d    = bus.din;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!last) begin
          cnt_d = cnt_q + 1'b1;
          sh_d  = sh_adv;
          // A word arriving mid-shift is parked until the current one ends.
          if (xfer) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Parked word has priority; din_ready is low here so no new transfer.
          sh_d        = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (xfer) begin
          // Word offered exactly on the last bit goes straight in, no gap.
          sh_d  = bus.din;
          cnt_d = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          sh_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer -- directed bench for byte_serializer: one MSB-first and
// one LSB-first instance sharing clock and reset. Inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_byte_serializer;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  byte_serializer_if #(.WIDTH(8)) ifm ();
  byte_serializer_if #(.WIDTH(8)) ifl ();

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bus(ifm)
  );
  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bus(ifl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    ifm.din = 8'hFF; ifm.din_valid = 1'b1;
    ifl.din = 8'hFF; ifl.din_valid = 1'b1;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({ifm.din_ready, ifm.ser_out, ifm.ser_valid, ifm.byte_done, ifm.busy} !== 5'b0) begin
        bad++;
        $display("FAIL reset_msb: rdy/out/vld/done/busy=%b expected 00000",
                 {ifm.din_ready, ifm.ser_out, ifm.ser_valid, ifm.byte_done, ifm.busy});
      end
      total++;
      if ({ifl.din_ready, ifl.ser_out, ifl.ser_valid, ifl.byte_done, ifl.busy} !== 5'b0) begin
        bad++;
        $display("FAIL reset_lsb: rdy/out/vld/done/busy=%b expected 00000",
                 {ifl.din_ready, ifl.ser_out, ifl.ser_valid, ifl.byte_done, ifl.busy});
      end
    end
    ifm.din_valid = 1'b0;
    ifl.din_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (ifm.din_ready !== 1'b1 || ifl.din_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: msb=%b lsb=%b expected 1 1", ifm.din_ready, ifl.din_ready);
    end
  endtask

  // 0x36 offered on the first edge after reset release.
  task automatic test_single();
    logic [7:0] w;
    w = 8'h36;
    ifm.din = w; ifm.din_valid = 1'b1;
    @(negedge clk);
    ifm.din_valid = 1'b0;
    ifm.din = 8'hAA;  // must not disturb the word in flight
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ifm.ser_valid !== 1'b1 || ifm.ser_out !== w[7-i] || ifm.byte_done !== (i == 7)
          || ifm.busy !== 1'b1) begin
        bad++;
        $display("FAIL single_bit%0d: out=%b vld=%b done=%b busy=%b expected out=%b vld=1 done=%b busy=1",
                 i, ifm.ser_out, ifm.ser_valid, ifm.byte_done, ifm.busy, w[7-i], (i == 7));
      end
      @(negedge clk);
    end
    total++;
    if (ifm.ser_valid !== 1'b0 || ifm.ser_out !== 1'b0 || ifm.busy !== 1'b0 || ifm.din_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_idle: vld=%b out=%b busy=%b rdy=%b expected 0 0 0 1",
               ifm.ser_valid, ifm.ser_out, ifm.busy, ifm.din_ready);
    end
  endtask

  // A5, 3C, FF with din_valid held: 24 gapless bits, ready low while hold is full.
  task automatic test_back_to_back();
    logic [23:0] s;
    logic        exp_rdy;
    s = 24'hA53CFF;
    ifm.din = 8'hA5; ifm.din_valid = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 24; c++) begin
      exp_rdy = (c == 1) || (c == 9) || (c >= 17);
      total++;
      if (ifm.ser_valid !== 1'b1 || ifm.ser_out !== s[24-c] || ifm.byte_done !== ((c % 8) == 0)) begin
        bad++;
        $display("FAIL b2b_bit%0d: out=%b vld=%b done=%b expected out=%b vld=1 done=%b",
                 c, ifm.ser_out, ifm.ser_valid, ifm.byte_done, s[24-c], ((c % 8) == 0));
      end
      total++;
      if (ifm.din_ready !== exp_rdy) begin
        bad++;
        $display("FAIL b2b_ready%0d: rdy=%b expected %b", c, ifm.din_ready, exp_rdy);
      end
      if (c == 1)  ifm.din = 8'h3C;
      if (c == 2)  ifm.din = 8'hFF;
      if (c == 10) ifm.din_valid = 1'b0;
      @(negedge clk);
    end
    total++;
    if (ifm.ser_valid !== 1'b0 || ifm.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: vld=%b busy=%b expected 0 0", ifm.ser_valid, ifm.busy);
    end
  endtask

  // C3 offered exactly on the last bit of 36 with the hold register empty.
  task automatic test_direct_load();
    logic [15:0] s;
    s = 16'h36C3;
    ifm.din = 8'h36; ifm.din_valid = 1'b1;
    @(negedge clk);
    ifm.din_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      total++;
      if (ifm.ser_valid !== 1'b1 || ifm.ser_out !== s[16-c] || ifm.byte_done !== ((c % 8) == 0)
          || ifm.din_ready !== 1'b1) begin
        bad++;
        $display("FAIL direct_bit%0d: out=%b vld=%b done=%b rdy=%b expected out=%b vld=1 done=%b rdy=1",
                 c, ifm.ser_out, ifm.ser_valid, ifm.byte_done, ifm.din_ready, s[16-c], ((c % 8) == 0));
      end
      if (c == 8) begin ifm.din = 8'hC3; ifm.din_valid = 1'b1; end
      if (c == 9) ifm.din_valid = 1'b0;
      @(negedge clk);
    end
    total++;
    if (ifm.ser_valid !== 1'b0 || ifm.busy !== 1'b0) begin
      bad++;
      $display("FAIL direct_idle: vld=%b busy=%b expected 0 0", ifm.ser_valid, ifm.busy);
    end
  endtask

  // 0x01 on the LSB-first instance.
  task automatic test_lsb_first();
    ifl.din = 8'h01; ifl.din_valid = 1'b1;
    @(negedge clk);
    ifl.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ifl.ser_valid !== 1'b1 || ifl.ser_out !== (i == 0) || ifl.byte_done !== (i == 7)) begin
        bad++;
        $display("FAIL lsb_bit%0d: out=%b vld=%b done=%b expected out=%b vld=1 done=%b",
                 i, ifl.ser_out, ifl.ser_valid, ifl.byte_done, (i == 0), (i == 7));
      end
      @(negedge clk);
    end
    total++;
    if (ifl.ser_valid !== 1'b0 || ifl.busy !== 1'b0) begin
      bad++;
      $display("FAIL lsb_idle: vld=%b busy=%b expected 0 0", ifl.ser_valid, ifl.busy);
    end
  endtask

  // Reset at bit 4 of F0 with 55 parked, then 0F must come out clean.
  task automatic test_reset_mid();
    logic [7:0] w;
    ifm.din = 8'hF0; ifm.din_valid = 1'b1;
    @(negedge clk);
    ifm.din = 8'h55;
    @(negedge clk);
    ifm.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (ifm.ser_valid !== 1'b1 || ifm.ser_out !== 1'b0 || ifm.busy !== 1'b1 || ifm.din_ready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_before: vld=%b out=%b busy=%b rdy=%b expected 1 0 1 0",
               ifm.ser_valid, ifm.ser_out, ifm.busy, ifm.din_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ifm.din_ready, ifm.ser_out, ifm.ser_valid, ifm.byte_done, ifm.busy} !== 5'b0) begin
      bad++;
      $display("FAIL rmid_async: rdy/out/vld/done/busy=%b expected 00000",
               {ifm.din_ready, ifm.ser_out, ifm.ser_valid, ifm.byte_done, ifm.busy});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (ifm.ser_valid !== 1'b0 || ifm.busy !== 1'b0 || ifm.ser_out !== 1'b0) begin
        bad++;
        $display("FAIL rmid_stale%0d: vld=%b busy=%b out=%b expected 0 0 0",
                 k, ifm.ser_valid, ifm.busy, ifm.ser_out);
      end
    end
    w = 8'h0F;
    ifm.din = w; ifm.din_valid = 1'b1;
    @(negedge clk);
    ifm.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ifm.ser_valid !== 1'b1 || ifm.ser_out !== w[7-i] || ifm.byte_done !== (i == 7)) begin
        bad++;
        $display("FAIL rmid_new_bit%0d: out=%b vld=%b done=%b expected out=%b vld=1 done=%b",
                 i, ifm.ser_out, ifm.ser_valid, ifm.byte_done, w[7-i], (i == 7));
      end
      @(negedge clk);
    end
    total++;
    if (ifm.ser_valid !== 1'b0 || ifm.busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_idle: vld=%b busy=%b expected 0 0", ifm.ser_valid, ifm.busy);
    end
  endtask

  // din_valid held while din toggles each cycle; only handshaked words may appear.
  task automatic test_toggle();
    logic [7:0] tbl [6];
    logic [7:0] exp_out [5];
    logic [7:0] q [$];
    logic [7:0] w;
    logic [7:0] e;
    int nout;
    int nin;
    tbl     = '{8'h11, 8'h9E, 8'h42, 8'hD7, 8'h6B, 8'hC8};
    exp_out = '{8'h11, 8'h9E, 8'hD7, 8'hC8, 8'h9E};
    w = '0; nout = 0; nin = 0;
    for (int c = 0; c < 60; c++) begin
      if (ifm.ser_valid === 1'b1) begin
        w = {w[6:0], ifm.ser_out};
        if (ifm.byte_done === 1'b1) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL toggle_extra: word %h emitted with none handshaked", w);
          end else begin
            e = q.pop_front();
            if (w !== e) begin
              bad++;
              $display("FAIL toggle_sb%0d: got %h expected %h", nout, w, e);
            end
          end
          total++;
          if (nout >= 5 || w !== exp_out[nout % 5]) begin
            bad++;
            $display("FAIL toggle_word%0d: got %h expected %h", nout, w, exp_out[nout % 5]);
          end
          nout++;
        end
      end
      if (c < 30) begin
        ifm.din = tbl[c % 6]; ifm.din_valid = 1'b1;
      end else begin
        ifm.din_valid = 1'b0;
      end
      #1;
      if (ifm.din_valid && ifm.din_ready) begin
        q.push_back(ifm.din);
        nin++;
      end
      @(negedge clk);
    end
    total++;
    if (nout != 5 || nin != 5 || q.size() != 0) begin
      bad++;
      $display("FAIL toggle_count: out=%0d in=%0d left=%0d expected 5 5 0", nout, nin, q.size());
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    total = 0;
    bad = 0;
    ifm.din = '0; ifm.din_valid = 1'b0;
    ifl.din = '0; ifl.din_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_direct_load();
    test_lsb_first();
    test_reset_mid();
    test_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter WIDTH, default 8, word width in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, bit order: 1 = MSB first, 0 = LSB first.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word offered for transfer.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 ser_out  output  1  serial bit stream; drives the downstream 1-bit sequence detector input.
REQ-009 ser_valid  output  1  ser_out carries a valid bit this cycle.
REQ-010 byte_done  output  1  ser_out carries the last bit of the current word.
REQ-011 busy  output  1  shifting is in progress, or the hold register is full.

Function
REQ-012 A transfer SHALL occur on each rising edge where din_valid=1 and din_ready=1; a word SHALL never be accepted without that handshake.
REQ-013 din_ready SHALL equal (NOT hold_full) AND rst_n, and SHALL be independent of din_valid (no combinational path from din_valid).
REQ-014 The FSM SHALL have exactly two states: IDLE (shift register empty) and SHIFT (a word is being output).
REQ-015 IDLE + transfer -> SHIFT; the word loads into the shift register; its first bit appears on ser_out, with ser_valid=1, in the cycle after the transfer edge (latency 1).
REQ-016 In SHIFT, each bit SHALL be presented for exactly one cycle; a word occupies exactly WIDTH consecutive cycles; a bit counter runs 0..WIDTH-1.
REQ-017 Bit order: counter value i presents din[WIDTH-1-i] when MSB_FIRST=1, and din[i] when MSB_FIRST=0.
REQ-018 byte_done SHALL be 1 exactly when the counter = WIDTH-1 and ser_valid=1.
REQ-019 A transfer in SHIFT when counter < WIDTH-1 SHALL store the word in a one-entry hold register and set hold_full.
REQ-020 At counter = WIDTH-1, the next-state priority is: (a) hold_full -> load from hold, clear hold_full; (b) else a transfer in that cycle -> load din directly; (c) else -> IDLE with ser_valid=0.
REQ-021 Loads under (a) and (b) SHALL give gapless output: the first bit of the next word immediately follows the last bit of the previous word; the counter wraps to 0.
REQ-022 At counter = WIDTH-1 with hold_full=1, din_ready=0, so no transfer can occur that cycle; the hold register SHALL never be overwritten.
REQ-023 In IDLE, ser_out SHALL be 0 and the counter SHALL be 0.
REQ-024 busy SHALL be (state = SHIFT) OR hold_full.
REQ-025 din SHALL be sampled only on transfer edges; changes to din at any other time SHALL have no effect.

Reset
REQ-026 While rst_n=0: state=IDLE, counter=0, hold_full=0, ser_out=0, ser_valid=0, byte_done=0, busy=0, din_ready=0.
REQ-027 Assertion of rst_n mid-word SHALL abort the word immediately, discard the shift and hold contents, and never emit the remaining bits.
REQ-028 A transfer SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-029 Reset, then a single word 0x36 with MSB_FIRST=1 -> ser_out 0,0,1,1,0,1,1,0 over 8 cycles with ser_valid=1; byte_done only on cycle 8; then IDLE.
REQ-030 din_valid held high with words 0xA5, 0x3C, 0xFF -> 24 contiguous valid bits, no gaps; din_ready drops while the hold register is full.
REQ-031 Second word offered exactly on the last-bit cycle with the hold register empty -> direct load; the next cycle shows bit 0 of the new word.
REQ-032 Word 0x01 with MSB_FIRST=0 -> ser_out 1,0,0,0,0,0,0,0.
REQ-033 rst_n pulsed low at bit 4 of 0xF0 with a word in the hold register -> all outputs 0 at once; after release no stale bits appear; a new word 0x0F serializes correctly.
REQ-034 din_valid=1 while din_ready=0, with din toggling -> only handshaked words appear on ser_out; no word is lost or duplicated (checked by scoreboard).
